// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, select codes and default-slave state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SEL_NONE       = 0;
  localparam int SEL_DEFAULT    = 1;
  localparam int SEL_SLAVE_BASE = 2;

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_ERR2 = 1'b1
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave: two-cycle ERROR FSM and error counter (AHB_RESP_MUX_DEFAULT_SLAVE_EN)
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     ahb_clk_in,
  input  logic                     ahb_rstn_in,
  input  logic                     sel_default,
  input  logic [1:0]               htrans,
  input  logic                     hready,
  output logic                     ds_hready,
  output logic                     ds_hresp,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

`ifdef AHB_RESP_MUX_DEFAULT_SLAVE_EN

  ds_state_t                state;
  logic                     data_active;
  logic                     htrans_active;

  assign htrans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // Data-phase tracking, ERROR sequencing and saturating error count
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state       <= DS_IDLE;
      data_active <= 1'b0;
      err_count   <= '0;
    end else begin
      if (hready) begin
        data_active <= htrans_active;
      end
      case (state)
        DS_IDLE: begin
          if (sel_default && data_active) begin
            state <= DS_ERR2;
          end
        end
        DS_ERR2: begin
          state <= DS_IDLE;
          if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
          end
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

  // First ERROR cycle stalls the bus; second cycle completes it whatever the select now says
  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    if (state == DS_ERR2) begin
      ds_hresp = HRESP_ERROR;
    end else if (sel_default && data_active) begin
      ds_hready = 1'b0;
      ds_hresp  = HRESP_ERROR;
    end
  end

`else

  logic unused_inputs;

  assign unused_inputs = ^{ahb_clk_in, ahb_rstn_in, sel_default, htrans, hready};
  assign ds_hready     = 1'b1;
  assign ds_hresp      = HRESP_OKAY;
  assign err_count     = '0;

`endif

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase response mux with default slave (AHB_RESP_MUX_DEFAULT_SLAVE_EN)
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int SLAVE_DEVICES  = 2,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rstn_in,
  input  logic [$clog2(SLAVE_DEVICES):0]          multi_sel_in,
  input  logic [1:0]                              ahb_htrans_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_hrdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hready_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hresp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_hrdata_out,
  output logic                                    ahb_hready_out,
  output logic                                    ahb_hresp_out,
  output logic [ERR_CNT_WIDTH-1:0]                err_count_out
);

  localparam int SEL_W = $clog2(SLAVE_DEVICES) + 1;

  logic                      sel_slave;
  logic                      sel_default;
  logic [AHB_DATA_WIDTH-1:0] slv_hrdata;
  logic                      slv_hready;
  logic                      slv_hresp;
  logic                      ds_hready;
  logic                      ds_hresp;

  // Decode the select code and pick out the addressed slave's response
  always_comb begin
    sel_slave  = 1'b0;
    slv_hrdata = '0;
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    for (int k = 0; k < SLAVE_DEVICES; k++) begin
      if (multi_sel_in == SEL_W'(SEL_SLAVE_BASE + k)) begin
        sel_slave  = 1'b1;
        slv_hrdata = slave_hrdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        slv_hready = slave_hready_in[k];
        slv_hresp  = slave_hresp_in[k];
      end
    end
    // Codes past the last slave are unmapped space too
    sel_default = (multi_sel_in == SEL_W'(SEL_DEFAULT)) ||
                  (!sel_slave && (multi_sel_in != SEL_W'(SEL_NONE)));
  end

  ahb_default_slave #(
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_default_slave (
    .ahb_clk_in  (ahb_clk_in),
    .ahb_rstn_in (ahb_rstn_in),
    .sel_default (sel_default),
    .htrans      (ahb_htrans_in),
    .hready      (ahb_hready_out),
    .ds_hready   (ds_hready),
    .ds_hresp    (ds_hresp),
    .err_count   (err_count_out)
  );

  // An in-flight default-slave ERROR owns the bus; otherwise slave passthrough or idle OKAY
  always_comb begin
    ahb_hrdata_out = '0;
    ahb_hready_out = 1'b1;
    ahb_hresp_out  = HRESP_OKAY;
    if (ds_hresp == HRESP_ERROR) begin
      ahb_hready_out = ds_hready;
      ahb_hresp_out  = HRESP_ERROR;
    end else if (sel_slave) begin
      ahb_hrdata_out = slv_hrdata;
      ahb_hready_out = slv_hready;
      ahb_hresp_out  = slv_hresp;
    end
  end

endmodule
